// File: rtl/fir_inverse.sv
// fir_inverse: deconvolution filter that undoes the team's direct-form FIR.
// It rebuilds x[n] = y[n] - sum_{i=1..N} K[i]*x[n-i] with one shared
// multiply-accumulate unit that handles one tap per cycle.
// A small sequencer walks IDLE -> MAC -> OUT.
// Optional build macro: FIR_INV_SAT_EN. When it is defined, an out-of-range
// result is clamped to the W_X limits. Otherwise the result wraps.
// m_err reports an out-of-range result in both builds.
module fir_inverse #(
    parameter int N   = 3,
    parameter int W_X = 4,
    parameter int W_K = 4,
    parameter int W_Y = W_X + W_K + $clog2(N),
    parameter logic signed [W_K-1:0] K [0:N] = '{4'sd1, 4'sd2, 4'sd3, 4'sd4}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic signed [W_Y-1:0] s_y,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic signed [W_X-1:0] m_x,
    output logic                  m_err
);

    // Accumulator width leaves headroom for y minus N products.
    localparam int W_A  = W_Y + W_K + 1;
    localparam int W_P  = W_K + W_X;
    localparam int HN   = (N < 1) ? 1 : N;
    localparam int W_I  = ($clog2(N + 1) < 1) ? 1 : $clog2(N + 1);

    localparam logic signed [W_A-1:0] X_MAX = W_A'((2 ** (W_X - 1)) - 1);
    localparam logic signed [W_A-1:0] X_MIN = -W_A'(2 ** (W_X - 1));

    // The inverse is only causal and exact when the leading tap is unity.
    generate
        if (K[0] != 1) begin : g_bad_k0
            $error("fir_inverse: K[0] must be 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic signed [W_A-1:0]   acc_q, acc_d;
    logic [W_I-1:0]          i_q, i_d;
    logic signed [W_X-1:0]   h_q [1:HN];
    logic signed [W_X-1:0]   h_d [1:HN];
    logic                    m_valid_q, m_valid_d;
    logic signed [W_X-1:0]   m_x_q, m_x_d;
    logic                    m_err_q, m_err_d;

    logic signed [W_K-1:0]   k_sel;
    logic signed [W_X-1:0]   h_sel;
    logic signed [W_P-1:0]   prod;
    logic signed [W_A-1:0]   prod_ext;
    logic                    acc_err;
    logic signed [W_X-1:0]   x_val;

    // Select the coefficient and history word addressed by the tap counter.
    always_comb begin
        k_sel = '0;
        h_sel = '0;
        for (int t = 1; t <= N; t++) begin
            if (i_q == W_I'(t)) begin
                k_sel = K[t];
                h_sel = h_q[t];
            end
        end
        prod     = k_sel * h_sel;
        prod_ext = {{(W_A - W_P){prod[W_P-1]}}, prod};
    end

    // Range check and output formatting of the finished accumulator.
    always_comb begin
        acc_err = (acc_q > X_MAX) || (acc_q < X_MIN);
`ifdef FIR_INV_SAT_EN
        if (acc_err) begin
            x_val = acc_q[W_A-1] ? X_MIN[W_X-1:0] : X_MAX[W_X-1:0];
        end else begin
            x_val = acc_q[W_X-1:0];
        end
`else
        x_val = acc_q[W_X-1:0];
`endif
    end

    // Sequencer: accept y, run N MAC cycles, then present one result.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        i_d       = i_q;
        h_d       = h_q;
        m_valid_d = m_valid_q;
        m_x_d     = m_x_q;
        m_err_d   = m_err_q;
        s_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    acc_d   = {{(W_A - W_Y){s_y[W_Y-1]}}, s_y};
                    i_d     = W_I'(1);
                    state_d = (N == 0) ? OUT : MAC;
                end
            end
            MAC: begin
                acc_d = acc_q - prod_ext;
                i_d   = i_q + W_I'(1);
                if (i_q == W_I'(N)) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                // The first OUT cycle registers m_x and m_err from the final
                // accumulator. After that they stay frozen until the handshake.
                if (!m_valid_q) begin
                    m_valid_d = 1'b1;
                    m_x_d     = x_val;
                    m_err_d   = acc_err;
                end else if (m_ready) begin
                    // History holds the emitted sample, so the inverse tracks
                    // exactly what downstream saw, even after wrap or clamp.
                    m_valid_d = 1'b0;
                    h_d[1]    = m_x_q;
                    for (int k = 2; k <= N; k++) begin
                        h_d[k] = h_q[k-1];
                    end
                    i_d     = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control, accumulator and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            i_q       <= '0;
            m_valid_q <= 1'b0;
            m_x_q     <= '0;
            m_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            i_q       <= i_d;
            m_valid_q <= m_valid_d;
            m_x_q     <= m_x_d;
            m_err_q   <= m_err_d;
        end
    end

    // History registers, one per tap.
    generate
        for (genvar gi = 1; gi <= HN; gi++) begin : g_hist
            // Clear on reset. Otherwise load the value the sequencer chose.
            always_ff @(posedge clk) begin
                if (rst) begin
                    h_q[gi] <= '0;
                end else begin
                    h_q[gi] <= h_d[gi];
                end
            end
        end
    endgenerate

    assign m_valid = m_valid_q;
    assign m_x     = m_x_q;
    assign m_err   = m_err_q;

endmodule

// File: tb/tb_fir_inverse.sv
// tb_fir_inverse: directed checks of fir_inverse with default parameters
// N=3, K={1,2,3,4}, W_X=4. A random run then passes through a FIR reference
// model. The run ends with one summary line.
module tb_fir_inverse;

    localparam int N   = 3;
    localparam int W_X = 4;
    localparam int W_K = 4;
    localparam int W_Y = W_X + W_K + $clog2(N);
    localparam int NR  = 200;

`ifdef FIR_INV_SAT_EN
    localparam int EXP9 = 7;
`else
    localparam int EXP9 = -7;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  s_valid;
    logic                  s_ready;
    logic signed [W_Y-1:0] s_y;
    logic                  m_valid;
    logic                  m_ready;
    logic signed [W_X-1:0] m_x;
    logic                  m_err;

    int n_cmp  = 0;
    int n_fail = 0;

    int k_tb [0:N] = '{1, 2, 3, 4};
    int xv [0:NR-1];
    int yv [0:NR-1];

    fir_inverse dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_y     (s_y),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_x     (m_x),
        .m_err   (m_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_y     = '0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One sample through the block. The caller starts #1 after a rising edge.
    // Checks the accept, a latency of 4 edges, the result, and the return to IDLE.
    task automatic xfer(input int y, input int ex, input int eerr,
                        input bit hold, input string tag);
        int lat;
        chk({tag, "_s_ready_in"}, s_ready, 1);
        s_valid = 1'b1;
        s_y     = W_Y'(y);
        m_ready = !hold;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        lat = 0;
        while (m_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 4);
        chk({tag, "_m_x"}, m_x, ex);
        chk({tag, "_m_err"}, m_err, eerr);
        if (hold) begin
            for (int c = 0; c < 5; c++) begin
                s_valid = c[0];
                s_y     = W_Y'(3);
                @(posedge clk);
                #1;
                chk({tag, "_hold_valid"}, m_valid, 1);
                chk({tag, "_hold_m_x"}, m_x, ex);
                chk({tag, "_hold_s_ready"}, s_ready, 0);
            end
            s_valid = 1'b0;
            m_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({tag, "_m_valid_out"}, m_valid, 0);
        chk({tag, "_s_ready_out"}, s_ready, 1);
    endtask

    initial begin
        int tx;
        int rx;
        int cyc;
        int acc;

        // Reset state
        do_reset();
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_x", m_x, 0);
        chk("rst_m_err", m_err, 0);

        // Basic reconstruction x = 1,2,3,4
        xfer(1, 1, 0, 0, "basic1");
        xfer(4, 2, 0, 0, "basic2");
        xfer(10, 3, 0, 0, "basic3");
        xfer(20, 4, 0, 0, "basic4");

        // Negative history and full-scale values
        do_reset();
        xfer(-8, -8, 0, 0, "neg1");
        xfer(-9, 7, 0, 0, "neg2");

        // Backpressure in OUT while s_valid pulses
        do_reset();
        xfer(1, 1, 0, 1, "hold");
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("hold_no_extra", m_valid, 0);
        end

        // Reset during MAC drops the sample and clears the history
        do_reset();
        xfer(1, 1, 0, 0, "mid1");
        xfer(4, 2, 0, 0, "mid2");
        s_valid = 1'b1;
        s_y     = W_Y'(10);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("mid_in_mac", s_ready, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_ready", s_ready, 1);
        chk("mid_rst_m_x", m_x, 0);
        xfer(5, 5, 0, 0, "mid_after");

        // Out-of-range result. The next sample recovers x=0 only if the
        // history holds the emitted value.
        do_reset();
        xfer(9, EXP9, 1, 0, "err9");
        xfer(2 * EXP9, 0, 0, 0, "err_next");

        // Random stream through the FIR model with random stalls
        do_reset();
        for (int n = 0; n < NR; n++) begin
            xv[n] = $urandom_range(0, 15) - 8;
        end
        for (int n = 0; n < NR; n++) begin
            acc = 0;
            for (int i = 0; i <= N; i++) begin
                if (n - i >= 0) acc += k_tb[i] * xv[n - i];
            end
            yv[n] = acc;
        end
        tx  = 0;
        rx  = 0;
        cyc = 0;
        while (rx < NR && cyc < 20000) begin
            s_valid = (tx < NR);
            if (tx < NR) s_y = W_Y'(yv[tx]);
            m_ready = ($urandom_range(0, 3) != 0);
            if (m_valid && m_ready) begin
                if (rx < NR) chk("rand_m_x", m_x, xv[rx]);
                rx++;
            end
            if (s_valid && s_ready) tx++;
            @(posedge clk);
            #1;
            cyc++;
        end
        s_valid = 1'b0;
        chk("rand_count", rx, NR);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
